// File: rtl/alu_flag_stage_pkg.sv
// Shared definitions for the unit_A result/flag stage.
// Flag bit positions, unit_A opcodes and the flag bundle type.
package alu_flag_stage_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] OP_SUM  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AINV = 2'b10;
    localparam logic [1:0] OP_INC  = 2'b11;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic flags_t make_flags(
        input logic msb,
        input logic zero,
        input logic c,
        input logic v
    );
        flags_t f;
        f.n = msb;
        f.z = zero;
        f.c = c;
        f.v = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_flag_stage_fifo2.sv
// Two-entry FIFO holding {flags, result} words.
// Explicit occupancy count keeps full/empty unambiguous with 1-bit pointers.
module flag_fifo2 #(
    parameter int DW = 36
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] e0_q, e0_d;
    logic [DW-1:0] e1_q, e1_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    cnt_q, cnt_d;

    // Next-state: write slot, pointer advance and occupancy update
    always_comb begin
        e0_d     = e0_q;
        e1_d     = e1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            if (wr_ptr_q) e1_d = wdata;
            else          e0_d = wdata;
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset discards every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q     <= '0;
            e1_q     <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            e0_q     <= e0_d;
            e1_q     <= e1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Head word, forced to zero when nothing is buffered
    always_comb begin
        rdata = '0;
        if (cnt_q != 2'd0) begin
            rdata = rd_ptr_q ? e1_q : e0_q;
        end
    end

    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/alu_flag_stage.sv
// Registered result/flag stage after unit_A: NZCV derivation,
// two-deep buffering, sticky overflow and saturating overflow counter.
module alu_flag_stage
    import alu_flag_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] S_in,
    input  logic             c_in,
    input  logic             o_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic [3:0]       flags,
    output logic             sticky_v,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] ovf_count
);

    flags_t               in_flags;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [WIDTH+3:0]     head;
    logic                 sticky_q, sticky_d;
    logic [CNT_W-1:0]     ovf_q, ovf_d;

    // Flags are pure pass-through of unit_A outputs plus sign/zero of S
    always_comb begin
        in_flags = make_flags(S_in[WIDTH-1], (S_in == '0), c_in, o_in);
    end

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    flag_fifo2 #(
        .DW(WIDTH + 4)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({in_flags, S_in}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign R     = head[WIDTH-1:0];
    assign flags = head[WIDTH+3:WIDTH];

    // Sticky overflow (set beats clear) and saturating event counter
    always_comb begin
        sticky_d = (sticky_q & ~clr_sticky) | (push & o_in);
        ovf_d    = ovf_q;
        if (push && o_in && (ovf_q != {CNT_W{1'b1}})) begin
            ovf_d = ovf_q + CNT_W'(1);
        end
    end

    // Overflow bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
            ovf_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
        end
    end

    assign sticky_v  = sticky_q;
    assign ovf_count = ovf_q;

endmodule

// File: tb/tb_alu_flag_stage.sv
// Bench for alu_flag_stage: unit_A behavioural model drives the stage,
// table vectors plus scoreboard-checked handshake sequences.
module tb_alu_flag_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        clr_sticky = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic [1:0]  F = '0;

    logic [31:0] S_in;
    logic        c_in, o_in;
    logic        in_ready, out_valid, sticky_v;
    logic [31:0] R;
    logic [3:0]  flags;
    logic [7:0]  ovf_count;
    logic        in_ready2, out_valid2, sticky_v2;
    logic [31:0] R2;
    logic [3:0]  flags2;
    logic [1:0]  ovf_count2;

    int n_checks = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    // unit_A model: returns {c, o, S}
    function automatic logic [33:0] ua(input logic [31:0] a, input logic [31:0] b,
                                       input logic [1:0] f);
        logic [32:0] t;
        logic o;
        case (f)
            2'b00: begin
                t = {1'b0, a} + {1'b0, b};
                o = (a[31] == b[31]) && (t[31] != a[31]);
            end
            2'b01: begin
                t = {1'b0, a} + {1'b0, ~b} + 33'd1;
                o = (a[31] != b[31]) && (t[31] != a[31]);
            end
            2'b10: begin
                t = {1'b0, ~a};
                o = 1'b0;
            end
            default: begin
                t = {1'b0, a} + 33'd1;
                o = ~a[31] & t[31];
            end
        endcase
        return {t[32], o, t[31:0]};
    endfunction

    logic [33:0] ua_out;
    assign ua_out = ua(A, B, F);
    assign S_in = ua_out[31:0];
    assign o_in = ua_out[32];
    assign c_in = ua_out[33];

    alu_flag_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .S_in(S_in), .c_in(c_in), .o_in(o_in), .out_valid(out_valid),
        .out_ready(out_ready), .R(R), .flags(flags), .sticky_v(sticky_v),
        .clr_sticky(clr_sticky), .ovf_count(ovf_count)
    );

    alu_flag_stage #(.WIDTH(32), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .S_in(S_in), .c_in(c_in), .o_in(o_in), .out_valid(out_valid2),
        .out_ready(out_ready), .R(R2), .flags(flags2), .sticky_v(sticky_v2),
        .clr_sticky(clr_sticky), .ovf_count(ovf_count2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
    } sb_t;

    sb_t         sb[$];
    logic        m_sticky = 1'b0;
    int unsigned m_ovf = 0;
    int unsigned m_ovf2 = 0;

    // Scoreboard monitor: compares current outputs, then advances the model
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            automatic int sz = sb.size();
            automatic bit p_push = in_valid && (sz < 2);
            automatic logic [33:0] u = ua(A, B, F);
            automatic sb_t e;
            check("in_ready", in_ready, sz < 2);
            check("out_valid", out_valid, sz != 0);
            check("in_ready_w2", in_ready2, sz < 2);
            check("sticky_v", sticky_v, m_sticky);
            check("sticky_v_w2", sticky_v2, m_sticky);
            check("ovf_count", ovf_count, m_ovf);
            check("ovf_count_w2", ovf_count2, m_ovf2);
            if (sz == 0) begin
                check("idle_out", {R, flags}, 36'h0);
            end else begin
                e = sb[0];
                check("head", {R, flags}, {e.r, e.f});
                check("head_w2", {R2, flags2}, {e.r, e.f});
                if (out_ready) void'(sb.pop_front());
            end
            if (p_push) begin
                e.r = u[31:0];
                e.f = {u[31], u[31:0] == 32'h0, u[33], u[32]};
                sb.push_back(e);
                if (u[32]) begin
                    if (m_ovf < 255) m_ovf++;
                    if (m_ovf2 < 3) m_ovf2++;
                end
            end
            m_sticky = (m_sticky & ~clr_sticky) | (p_push & u[32]);
        end
    end

    // Hold a result on the inputs until the stage accepts it
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
        bit ok = 1'b0;
        bit acc;
        A = a; B = b; F = f; in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            ok = acc;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
    endtask

    task automatic drain();
        int i = 0;
        while (sb.size() != 0 && i < 20) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("drain", sb.size(), 0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  f;
        logic [31:0] r;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'd6,        32'd6, 2'b00, 32'h0000000C, 4'b0000};
        vecs[1] = '{32'd6,        32'd6, 2'b01, 32'h00000000, 4'b0110};
        vecs[2] = '{32'h7FFFFFFF, 32'd1, 2'b00, 32'h80000000, 4'b1001};
        vecs[3] = '{32'hFFFFFFFF, 32'd1, 2'b00, 32'h00000000, 4'b0110};
        vecs[4] = '{32'h00000000, 32'd1, 2'b01, 32'hFFFFFFFF, 4'b1000};
        vecs[5] = '{32'h80000000, 32'd1, 2'b01, 32'h7FFFFFFF, 4'b0011};
        vecs[6] = '{32'h12345678, 32'd0, 2'b10, 32'hEDCBA987, 4'b1000};
        vecs[7] = '{32'h7FFFFFFF, 32'd0, 2'b11, 32'h80000000, 4'b1001};
        vecs[8] = '{32'hFFFFFFFF, 32'd0, 2'b11, 32'h00000000, 4'b0110};

        // reset state
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_R_flags", {R, flags}, 36'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // table vectors, one push each, consumer always ready
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].f);
            in_valid = 1'b0;
            check($sformatf("vec%0d", i), {R, flags}, {vecs[i].r, vecs[i].fl});
            if (i == 0) check("vec0_sticky", sticky_v, 1'b0);
            if (i == 2) begin
                check("vec2_sticky", sticky_v, 1'b1);
                check("vec2_ovf", ovf_count, 8'd1);
            end
        end
        drain();

        // backpressure: three results, consumer stalled
        out_ready = 1'b0;
        send(32'd1, 32'd2, 2'b00);
        send(32'd10, 32'd3, 2'b01);
        A = 32'd0; B = 32'd0; F = 2'b10;
        repeat (3) @(posedge clk);
        #1;
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_head", {R, flags}, {32'd3, 4'b0000});
        out_ready = 1'b1;
        send(32'd0, 32'd0, 2'b10);
        in_valid = 1'b0;
        drain();

        // steady push+pop at occupancy 1
        send(32'd100, 32'd0, 2'b11);
        for (int i = 0; i < 10; i++) begin
            send(32'd200 + i, 32'd7, 2'(i % 4));
            check("pp_out_valid", out_valid, 1'b1);
            check("pp_in_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        drain();

        // sticky: set beats clear, then clear alone
        clr_sticky = 1'b1;
        send(32'h7FFFFFFF, 32'd1, 2'b00);
        in_valid = 1'b0;
        clr_sticky = 1'b0;
        check("sticky_set_wins", sticky_v, 1'b1);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        check("sticky_cleared", sticky_v, 1'b0);
        check("ovf_kept", ovf_count, 8'(m_ovf));
        drain();

        // counter saturation on the narrow instance
        for (int i = 0; i < 5; i++) send(32'h7FFFFFFF, 32'd1, 2'b00);
        in_valid = 1'b0;
        drain();
        check("sat_ovf_w2", ovf_count2, 2'd3);

        // asynchronous reset with two entries buffered
        out_ready = 1'b0;
        send(32'd5, 32'd5, 2'b00);
        send(32'h7FFFFFFF, 32'd1, 2'b00);
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_R_flags", {R, flags}, 36'h0);
        check("arst_sticky", sticky_v, 1'b0);
        check("arst_ovf", ovf_count, 8'd0);
        check("arst_ovf_w2", ovf_count2, 2'd0);
        sb.delete();
        m_sticky = 1'b0;
        m_ovf = 0;
        m_ovf2 = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(32'd1, 32'd1, 2'b00);
        in_valid = 1'b0;
        check("post_rst", {R, flags}, {32'd2, 4'b0000});
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
